// File: rtl/fetch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : fetch_pkg                                                  |
// | Purpose  : Shared constants, FSM state encoding and output-select     |
// |            encoding for the WISC-SP13 instruction-fetch stage.        |
// | Contents : NOP_INSTR_DEFAULT - bubble encoding (opcode 00001)         |
// |            HALT_OPCODE       - opcode that stops fetch                |
// |            fetch_state_t     - FETCH/WAIT/HOLD/DRAIN/HALTED           |
// |            out_sel_t         - source of instr_out                    |
// |            is_halt()         - opcode decode helper                   |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
package fetch_pkg;

  localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE       = 5'b00000;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEL_NOP  = 2'd0,
    SEL_MEM  = 2'd1,
    SEL_HOLD = 2'd2
  } out_sel_t;

  function automatic logic is_halt(input logic [15:0] instr);
    return (instr[15:11] == HALT_OPCODE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fsm.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : fetch_fsm                                                  |
// | Purpose  : Control FSM of the fetch stage. Tracks the outstanding     |
// |            instruction-memory read, decides which source drives       |
// |            instr_out and emits strobes for the PC/hold datapath.      |
// | Ports    : clk, rst          - clock, synchronous active-high reset   |
// |            stall_in          - decode did not consume this cycle      |
// |            redirect_in       - taken branch/jump from downstream      |
// |            imem_done         - memory read completes this cycle       |
// |            data_is_halt      - imem_data carries a HALT opcode        |
// |            hold_is_halt      - hold register carries a HALT opcode    |
// |            imem_rd           - read request to instruction memory     |
// |            out_sel           - instr_out source (NOP / memory / hold) |
// |            flush, halted     - squash-bubble flag, fetch stopped      |
// |            pc_advance        - step PC by 2                           |
// |            hold_capture      - load hold register from imem_data      |
// |            hold_release      - hold register contents consumed        |
// |            drain_start       - latch current PC as drain address      |
// |            use_drain_addr    - drive imem_addr from drain address     |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module fetch_fsm
  import fetch_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     stall_in,
  input  logic     redirect_in,
  input  logic     imem_done,
  input  logic     data_is_halt,
  input  logic     hold_is_halt,
  output logic     imem_rd,
  output out_sel_t out_sel,
  output logic     flush,
  output logic     halted,
  output logic     pc_advance,
  output logic     hold_capture,
  output logic     hold_release,
  output logic     drain_start,
  output logic     use_drain_addr
);

  fetch_state_t state_q;
  fetch_state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    imem_rd        = 1'b0;
    out_sel        = SEL_NOP;
    flush          = 1'b0;
    halted         = 1'b0;
    pc_advance     = 1'b0;
    hold_capture   = 1'b0;
    hold_release   = 1'b0;
    drain_start    = 1'b0;
    use_drain_addr = 1'b0;

    case (state_q)
      // FETCH and WAIT differ only in how they were entered; both keep the
      // request up at pc_q and react identically to imem_done.
      ST_FETCH, ST_WAIT: begin
        imem_rd = 1'b1;
        if (redirect_in) begin
          flush = 1'b1;
          if (imem_done) begin
            state_d = ST_FETCH;
          end else begin
            // The memory still owes us a word for the old address; it must
            // be allowed to finish before a new address is presented.
            state_d     = ST_DRAIN;
            drain_start = 1'b1;
          end
        end else if (imem_done) begin
          out_sel    = SEL_MEM;
          // A HALT never moves the PC past itself.
          pc_advance = !data_is_halt;
          if (stall_in) begin
            hold_capture = 1'b1;
            state_d      = ST_HOLD;
          end else if (data_is_halt) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_HOLD: begin
        if (redirect_in) begin
          flush        = 1'b1;
          hold_release = 1'b1;
          state_d      = ST_FETCH;
        end else begin
          out_sel = SEL_HOLD;
          if (!stall_in) begin
            hold_release = 1'b1;
            state_d      = hold_is_halt ? ST_HALTED : ST_FETCH;
          end
        end
      end

      ST_DRAIN: begin
        imem_rd        = 1'b1;
        use_drain_addr = 1'b1;
        // A second redirect only retargets pc_q; the drain address stays.
        if (redirect_in) begin
          flush = 1'b1;
        end
        if (imem_done) begin
          state_d = ST_FETCH;
        end
      end

      ST_HALTED: begin
        halted = 1'b1;
        if (redirect_in) begin
          flush   = 1'b1;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // Reset abandons any outstanding read and suppresses every output.
    if (rst) begin
      state_d        = ST_FETCH;
      imem_rd        = 1'b0;
      out_sel        = SEL_NOP;
      flush          = 1'b0;
      halted         = 1'b0;
      pc_advance     = 1'b0;
      hold_capture   = 1'b0;
      hold_release   = 1'b0;
      drain_start    = 1'b0;
      use_drain_addr = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : fetch_stage                                                |
// | Purpose  : Instruction-fetch stage of the 5-stage WISC-SP13 pipeline. |
// |            Owns the PC, drives the stalling instruction memory and    |
// |            presents instruction + PC+2 to the fetch/decode register.  |
// | Params   : RESET_PC  - PC loaded by reset                             |
// |            NOP_INSTR - bubble encoding                                |
// | Ports    : clk, rst              - clock, sync active-high reset      |
// |            stall_in              - decode hazard, output not consumed |
// |            redirect_in/_pc       - taken branch/jump and its target   |
// |            imem_addr/rd          - memory request (held until done)   |
// |            imem_data/done/stall  - memory response                    |
// |            instr_out, pc_out     - instruction and its address + 2    |
// |            flush_out             - instr_out is a redirect bubble     |
// |            halted_out            - fetch stopped after HALT           |
// |            err_out               - misaligned target seen (sticky)    |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEFAULT
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        imem_stall,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic        flush_out,
  output logic        halted_out,
  output logic        err_out
);

  // Memory busy is implied by imem_done being low; the flag itself is
  // not needed by the control path.
  logic unused_imem_stall;
  assign unused_imem_stall = imem_stall;

  logic [15:0] pc_q;
  logic [15:0] pc_plus2;
  logic [15:0] drain_addr;
  logic [15:0] hold_instr;
  logic [15:0] hold_pc;
  logic        hold_valid;
  logic        err_q;

  out_sel_t    out_sel;
  logic        pc_advance;
  logic        hold_capture;
  logic        hold_release;
  logic        drain_start;
  logic        use_drain_addr;
  logic        hold_is_halt;

  assign pc_plus2     = pc_q + 16'd2;
  assign hold_is_halt = hold_valid && is_halt(hold_instr);

  fetch_fsm u_fsm (
    .clk            (clk),
    .rst            (rst),
    .stall_in       (stall_in),
    .redirect_in    (redirect_in),
    .imem_done      (imem_done),
    .data_is_halt   (is_halt(imem_data)),
    .hold_is_halt   (hold_is_halt),
    .imem_rd        (imem_rd),
    .out_sel        (out_sel),
    .flush          (flush_out),
    .halted         (halted_out),
    .pc_advance     (pc_advance),
    .hold_capture   (hold_capture),
    .hold_release   (hold_release),
    .drain_start    (drain_start),
    .use_drain_addr (use_drain_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      drain_addr <= RESET_PC;
      hold_instr <= NOP_INSTR;
      hold_pc    <= 16'h0000;
      hold_valid <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Redirect wins over every other PC update. Bit 0 is forced low so
      // fetch stays word-aligned; the misalignment is only reported.
      if (redirect_in) begin
        pc_q <= {redirect_pc[15:1], 1'b0};
        if (redirect_pc[0]) begin
          err_q <= 1'b1;
        end
      end else if (pc_advance) begin
        pc_q <= pc_plus2;
      end

      // Remember the address of the read still in flight so the memory
      // sees a stable address while it is drained.
      if (drain_start) begin
        drain_addr <= pc_q;
      end

      if (redirect_in) begin
        hold_valid <= 1'b0;
      end else if (hold_capture) begin
        hold_instr <= imem_data;
        hold_pc    <= pc_plus2;
        hold_valid <= 1'b1;
      end else if (hold_release) begin
        hold_valid <= 1'b0;
      end
    end
  end

  assign imem_addr = use_drain_addr ? drain_addr : pc_q;
  assign err_out   = err_q & ~rst;

  always_comb begin
    instr_out = NOP_INSTR;
    pc_out    = pc_plus2;
    case (out_sel)
      SEL_MEM: begin
        instr_out = imem_data;
      end
      SEL_HOLD: begin
        instr_out = hold_instr;
        pc_out    = hold_pc;
      end
      default: begin
        instr_out = NOP_INSTR;
      end
    endcase
    if (rst) begin
      pc_out = 16'h0000;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_fetch_stage                                             |
// | Purpose  : Self-checking bench for fetch_stage: latency-programmable  |
// |            memory responder, directed scenarios and a randomized run  |
// |            checked against a program-order fetch model.               |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        redirect_in;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data  = 16'hDEAD;
  logic        imem_done  = 1'b0;
  logic        imem_stall = 1'b0;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic        flush_out;
  logic        halted_out;
  logic        err_out;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] mem [0:32767];

  // Memory latency: 0 = always zero-wait, 1 = slow_lat cycles on slow_addr
  // only, 2 = random 0..3 per request.
  int          lat_mode  = 0;
  logic [15:0] slow_addr = 16'h0000;
  int          slow_lat  = 0;

  bit          req_active = 0;
  bit          prev_done  = 0;
  logic [15:0] req_addr   = 16'h0000;
  int          req_cnt    = 0;
  int          req_lat    = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall_in    (stall_in),
    .redirect_in (redirect_in),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .imem_data   (imem_data),
    .imem_done   (imem_done),
    .imem_stall  (imem_stall),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .flush_out   (flush_out),
    .halted_out  (halted_out),
    .err_out     (err_out)
  );

  // Memory responder: inputs change at posedge+1, response at posedge+2.
  always begin
    @(posedge clk);
    #2;
    if (rst || !imem_rd) begin
      req_active = 0;
      prev_done  = 0;
      imem_done  = 1'b0;
      imem_stall = 1'b0;
      imem_data  = 16'hDEAD;
    end else begin
      if (!req_active || prev_done || imem_addr != req_addr) begin
        req_active = 1;
        req_addr   = imem_addr;
        req_cnt    = 0;
        if (lat_mode == 0)      req_lat = 0;
        else if (lat_mode == 1) req_lat = (imem_addr == slow_addr) ? slow_lat : 0;
        else                    req_lat = $urandom_range(0, 3);
      end else begin
        req_cnt++;
      end
      imem_done  = (req_cnt >= req_lat);
      imem_stall = !imem_done;
      prev_done  = imem_done;
      imem_data  = imem_done ? mem[imem_addr[15:1]] : 16'hDEAD;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall_in = 1'b0; redirect_in = 1'b0; redirect_pc = 16'h0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_in = 1'b0; redirect_in = 1'b0; redirect_pc = 16'h0000;
    for (int k = 0; k < 2; k++) begin
      settle();
      tests_run++;
      if (imem_rd !== 1'b0 || instr_out !== NOP || pc_out !== 16'h0000 ||
          flush_out !== 1'b0 || halted_out !== 1'b0 || err_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset[%0d]: rd=%b instr=%h pc_out=%h flush=%b halted=%b err=%b expected 0,0800,0000,0,0,0",
                 k, imem_rd, instr_out, pc_out, flush_out, halted_out, err_out);
      end
      tick();
    end
  endtask

  // Randomized run: every consumed instruction must be the next word in
  // program order, where program order restarts at each redirect target.
  task automatic test_random();
    logic [15:0] exp_pc;
    logic [15:0] tgt;
    bit          err_exp;
    bit          stl;
    bit          rdr;
    int          consumed;
    do_reset();
    lat_mode = 2;
    exp_pc   = 16'h0000;
    err_exp  = 0;
    consumed = 0;
    for (int c = 0; c < 400; c++) begin
      stl = ($urandom_range(0, 3) == 0);
      rdr = ($urandom_range(0, 15) == 0);
      tgt = 16'($urandom);
      stall_in = stl; redirect_in = rdr; redirect_pc = tgt;
      settle();
      tests_run++;
      if (err_out !== err_exp) begin
        tests_failed++;
        $display("FAIL random_err[%0d]: got %b expected %b", c, err_out, err_exp);
      end
      if (rdr) begin
        tests_run++;
        if (flush_out !== 1'b1 || instr_out !== NOP) begin
          tests_failed++;
          $display("FAIL random_flush[%0d]: flush=%b instr=%h expected 1,0800", c, flush_out, instr_out);
        end
        exp_pc  = tgt & 16'hFFFE;
        err_exp = err_exp | tgt[0];
      end else begin
        tests_run++;
        if (flush_out !== 1'b0) begin
          tests_failed++;
          $display("FAIL random_noflush[%0d]: got %b expected 0", c, flush_out);
        end
        if (!stl && instr_out !== NOP) begin
          tests_run++;
          if (instr_out !== mem[exp_pc[15:1]] || pc_out !== exp_pc + 16'd2) begin
            tests_failed++;
            $display("FAIL random_stream[%0d]: instr=%h pc_out=%h expected %h,%h",
                     c, instr_out, pc_out, mem[exp_pc[15:1]], exp_pc + 16'd2);
          end
          exp_pc = exp_pc + 16'd2;
          consumed++;
        end
      end
      tick();
    end
    stall_in = 1'b0; redirect_in = 1'b0;
    tests_run++;
    if (consumed < 40) begin
      tests_failed++;
      $display("FAIL random_progress: consumed %0d expected at least 40", consumed);
    end
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 4; i++) mem[i] = 16'h4000 + 16'(i);
    lat_mode = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      settle();
      tests_run++;
      if (instr_out !== 16'h4000 + 16'(i) || pc_out !== 16'(2 * (i + 1)) ||
          imem_addr !== 16'(2 * i) || imem_rd !== 1'b1) begin
        tests_failed++;
        $display("FAIL zero_wait[%0d]: instr=%h pc_out=%h addr=%h rd=%b expected %h,%h,%h,1",
                 i, instr_out, pc_out, imem_addr, imem_rd, 16'h4000 + 16'(i), 16'(2 * (i + 1)), 16'(2 * i));
      end
      tick();
    end
  endtask

  task automatic test_wait();
    mem[16'h0008] = 16'h5A5A;
    lat_mode = 1; slow_addr = 16'h0010; slow_lat = 3;
    do_reset();
    redirect_in = 1'b1; redirect_pc = 16'h0010;
    settle();
    tests_run++;
    if (flush_out !== 1'b1 || instr_out !== NOP) begin
      tests_failed++;
      $display("FAIL wait_redirect: flush=%b instr=%h expected 1,0800", flush_out, instr_out);
    end
    tick();
    redirect_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      tests_run++;
      if (imem_addr !== 16'h0010 || imem_rd !== 1'b1 ||
          instr_out !== ((k < 3) ? NOP : 16'h5A5A) || (k == 3 && pc_out !== 16'h0012)) begin
        tests_failed++;
        $display("FAIL wait[%0d]: addr=%h rd=%b instr=%h pc_out=%h expected 0010,1,%h,0012",
                 k, imem_addr, imem_rd, instr_out, pc_out, (k < 3) ? NOP : 16'h5A5A);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    mem[0] = 16'h4000; mem[1] = 16'h1234; mem[2] = 16'h4444;
    lat_mode = 0;
    do_reset();
    settle();
    tick();
    for (int k = 0; k < 3; k++) begin
      stall_in = (k < 2);
      settle();
      tests_run++;
      if (instr_out !== 16'h1234 || pc_out !== 16'h0004 || imem_rd !== (k == 0)) begin
        tests_failed++;
        $display("FAIL stall[%0d]: instr=%h pc_out=%h rd=%b expected 1234,0004,%b",
                 k, instr_out, pc_out, imem_rd, (k == 0));
      end
      tick();
    end
    stall_in = 1'b0;
    settle();
    tests_run++;
    if (imem_addr !== 16'h0004 || imem_rd !== 1'b1 || instr_out !== 16'h4444 || pc_out !== 16'h0006) begin
      tests_failed++;
      $display("FAIL stall_resume: addr=%h rd=%b instr=%h pc_out=%h expected 0004,1,4444,0006",
               imem_addr, imem_rd, instr_out, pc_out);
    end
    tick();
  endtask

  task automatic test_redirect_wait();
    mem[0] = 16'h7777; mem[16'h0080] = 16'h3C3C;
    lat_mode = 1; slow_addr = 16'h0000; slow_lat = 3;
    do_reset();
    settle();
    tick();
    redirect_in = 1'b1; redirect_pc = 16'h0100;
    settle();
    tests_run++;
    if (flush_out !== 1'b1 || instr_out !== NOP) begin
      tests_failed++;
      $display("FAIL redir_wait_flush: flush=%b instr=%h expected 1,0800", flush_out, instr_out);
    end
    tick();
    redirect_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      tests_run++;
      if (imem_addr !== 16'h0000 || imem_rd !== 1'b1 || instr_out !== NOP || flush_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL redir_drain[%0d]: addr=%h rd=%b instr=%h flush=%b expected 0000,1,0800,0",
                 k, imem_addr, imem_rd, instr_out, flush_out);
      end
      tick();
    end
    settle();
    tests_run++;
    if (imem_addr !== 16'h0100 || instr_out !== 16'h3C3C || pc_out !== 16'h0102) begin
      tests_failed++;
      $display("FAIL redir_target: addr=%h instr=%h pc_out=%h expected 0100,3C3C,0102",
               imem_addr, instr_out, pc_out);
    end
    tick();
  endtask

  task automatic test_halt();
    mem[16'h0010] = 16'h0000; mem[16'h0020] = 16'h2468;
    lat_mode = 0;
    do_reset();
    redirect_in = 1'b1; redirect_pc = 16'h0020;
    settle();
    tick();
    redirect_in = 1'b0;
    settle();
    tests_run++;
    if (instr_out !== 16'h0000 || pc_out !== 16'h0022 || halted_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_present: instr=%h pc_out=%h halted=%b expected 0000,0022,0", instr_out, pc_out, halted_out);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      settle();
      tests_run++;
      if (instr_out !== NOP || halted_out !== 1'b1 || imem_rd !== 1'b0) begin
        tests_failed++;
        $display("FAIL halted[%0d]: instr=%h halted=%b rd=%b expected 0800,1,0", k, instr_out, halted_out, imem_rd);
      end
      tick();
    end
    redirect_in = 1'b1; redirect_pc = 16'h0040;
    settle();
    tests_run++;
    if (flush_out !== 1'b1 || instr_out !== NOP) begin
      tests_failed++;
      $display("FAIL halt_redirect: flush=%b instr=%h expected 1,0800", flush_out, instr_out);
    end
    tick();
    redirect_in = 1'b0;
    settle();
    tests_run++;
    if (imem_addr !== 16'h0040 || imem_rd !== 1'b1 || halted_out !== 1'b0 || instr_out !== 16'h2468) begin
      tests_failed++;
      $display("FAIL halt_resume: addr=%h rd=%b halted=%b instr=%h expected 0040,1,0,2468",
               imem_addr, imem_rd, halted_out, instr_out);
    end
    tick();
  endtask

  task automatic test_halt_stall();
    mem[16'h0010] = 16'h0000;
    lat_mode = 0;
    do_reset();
    redirect_in = 1'b1; redirect_pc = 16'h0020;
    settle();
    tick();
    redirect_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      stall_in = (k == 0);
      settle();
      tests_run++;
      if (instr_out !== 16'h0000 || halted_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL halt_hold[%0d]: instr=%h halted=%b expected 0000,0", k, instr_out, halted_out);
      end
      tick();
    end
    stall_in = 1'b0;
    settle();
    tests_run++;
    if (instr_out !== NOP || halted_out !== 1'b1 || imem_rd !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_after_hold: instr=%h halted=%b rd=%b expected 0800,1,0", instr_out, halted_out, imem_rd);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    bit found;
    mem[16'h0028] = 16'h1357;
    lat_mode = 1; slow_addr = 16'h0000; slow_lat = 3;
    do_reset();
    settle();
    tick();
    rst = 1'b1;
    settle();
    tests_run++;
    if (imem_rd !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_wait: rd=%b expected 0", imem_rd);
    end
    tick();
    rst = 1'b0; redirect_in = 1'b1; redirect_pc = 16'h0051;
    settle();
    tests_run++;
    if (imem_rd !== 1'b1 || imem_addr !== 16'h0000 || err_out !== 1'b0 || flush_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL after_reset: rd=%b addr=%h err=%b flush=%b expected 1,0000,0,1",
               imem_rd, imem_addr, err_out, flush_out);
    end
    tick();
    redirect_in = 1'b0;
    settle();
    tests_run++;
    if (err_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_set: got %b expected 1", err_out);
    end
    tick();
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      settle();
      if (imem_rd === 1'b1 && imem_addr === 16'h0050) begin
        found = 1;
        tests_run++;
        if (instr_out !== 16'h1357 || pc_out !== 16'h0052 || err_out !== 1'b1) begin
          tests_failed++;
          $display("FAIL misaligned_fetch: instr=%h pc_out=%h err=%b expected 1357,0052,1",
                   instr_out, pc_out, err_out);
        end
      end
      tick();
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL misaligned_timeout: no request at 0050 seen, expected one within 12 cycles");
    end
  endtask

  task automatic test_wrap();
    mem[16'h7FFF] = 16'h9ABC;
    lat_mode = 0;
    do_reset();
    redirect_in = 1'b1; redirect_pc = 16'hFFFE;
    settle();
    tick();
    redirect_in = 1'b0;
    settle();
    tests_run++;
    if (imem_addr !== 16'hFFFE || instr_out !== 16'h9ABC || pc_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL wrap_fetch: addr=%h instr=%h pc_out=%h expected FFFE,9ABC,0000", imem_addr, instr_out, pc_out);
    end
    tick();
    settle();
    tests_run++;
    if (imem_addr !== 16'h0000) begin
      tests_failed++;
      $display("FAIL wrap_next: addr=%h expected 0000", imem_addr);
    end
    tick();
  endtask

  initial begin
    logic [4:0] op;
    rst = 1'b1; stall_in = 1'b0; redirect_in = 1'b0; redirect_pc = 16'h0000;
    // Random program with opcodes 2..31 only: no HALTs and no word that
    // looks like a bubble.
    for (int i = 0; i < 32768; i++) begin
      op     = 5'($urandom_range(2, 31));
      mem[i] = {op, 11'($urandom)};
    end
    @(posedge clk);
    #1;
    test_reset();
    test_random();
    test_zero_wait();
    test_wait();
    test_stall();
    test_redirect_wait();
    test_halt();
    test_halt_stall();
    test_reset_mid_wait();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
